amba3_apb_mem_slave: RTL and testbench

AMBA3_APB_MEM_SLAVE -- requirements
Module: amba3_apb_mem_slave

---
 rtl/amba3_apb_mem_slave_pkg.sv | 26 ++
 rtl/amba3_apb_mem_slave_if.sv | 25 ++
 rtl/amba3_apb_mem_array.sv | 40 ++++
 rtl/amba3_apb_mem_slave.sv | 188 ++++++++++++++++++
 tb/tb_amba3_apb_mem_slave.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/amba3_apb_mem_slave_pkg.sv
// Shared types for the AMBA3 APB memory slave: transfer FSM states,
// the per-transfer response bundle and a wait-count clamp helper.
package pkg_amba3;

    // Widest legal data bus; the response struct is sized for it and
    // narrower instances use the low bits.
    localparam int MAX_DATA_SIZE = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic [MAX_DATA_SIZE-1:0] prdata;
        logic                     pslverr;
    } apb_resp_t;

    // Wait requests above the configured maximum are served at the maximum.
    function automatic logic [31:0] clamp_wait(input logic [31:0] req,
                                               input logic [31:0] max_w);
        return (req > max_w) ? max_w : req;
    endfunction

endpackage

// File: rtl/amba3_apb_mem_slave_if.sv
// APB bus bundle between a master and the memory slave.
interface amba3_apb_mem_slave_if #(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32
);
    logic                   psel;
    logic                   penable;
    logic                   pwrite;
    logic [ADDR_SIZE-1:0]   paddr;
    logic [DATA_SIZE-1:0]   pwdata;
    logic [DATA_SIZE/8-1:0] pstrb;
    logic [DATA_SIZE-1:0]   prdata;
    logic                   pready;
    logic                   pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/amba3_apb_mem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_SIZE, with per-byte write
// enables and a registered read port. Each byte lane is its own array so
// the byte-enable write maps onto block RAM without read-modify-write.
module amba3_apb_mem_array #(
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 1024
) (
    input  logic                         clk,
    input  logic                         en,
    input  logic                         we,
    input  logic [DATA_SIZE/8-1:0]       be,
    input  logic [$clog2(DEPTH)-1:0]     addr,
    input  logic [DATA_SIZE-1:0]         wdata,
    output logic [DATA_SIZE-1:0]         rdata
);
    localparam int LANES = DATA_SIZE / 8;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] q_reg;

            // Lane write when enabled, otherwise registered read; the read
            // register holds its value between reads.
            always_ff @(posedge clk) begin
                if (en) begin
                    if (we) begin
                        if (be[gi]) begin
                            mem[addr] <= wdata[gi*8 +: 8];
                        end
                    end else begin
                        q_reg <= mem[addr];
                    end
                end
            end

            assign rdata[gi*8 +: 8] = q_reg;
        end
    endgenerate
endmodule

// File: rtl/amba3_apb_mem_slave.sv
// AMBA3 APB memory slave with programmable wait states.
// Transfer length is 2 + min(wait_cfg, MAX_WAIT) cycles; misaligned or
// out-of-range accesses answer with pslverr and leave memory untouched.
// Optional feature macro: AMBA3_APB_PSTRB_EN enables byte-lane write
// strobes; without it pstrb is ignored and writes cover the full word.
module amba3_apb_mem_slave
    import pkg_amba3::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 1024,
    parameter int MAX_WAIT  = 15
) (
    input  logic                          pclk,
    input  logic                          preset,
    input  logic [$clog2(MAX_WAIT+1)-1:0] wait_cfg,
    amba3_apb_mem_slave_if.slave          apb
);
    localparam int LANES = DATA_SIZE / 8;
    localparam int LSB   = $clog2(LANES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    apb_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             pready_reg, pready_next;
    logic             pslverr_reg, pslverr_next;
    logic             rd_valid_reg, rd_valid_next;
    logic [IDX_W-1:0] addr_reg, addr_next;
    logic             write_reg, write_next;
    logic             err_reg, err_next;

    logic             ram_en;
    logic             ram_we;
    logic [LANES-1:0] ram_be;
    logic [IDX_W-1:0] ram_addr;
    logic [DATA_SIZE-1:0] ram_rdata;

    logic [ADDR_SIZE-1:0] word_idx;
    logic [IDX_W-1:0]     bus_idx;
    logic                 addr_err;
    logic [CNT_W-1:0]     wait_clamped;
    logic [LANES-1:0]     wr_be;
    apb_resp_t            resp;

    assign word_idx     = apb.paddr >> LSB;
    assign bus_idx      = word_idx[IDX_W-1:0];
    assign addr_err     = (word_idx >= ADDR_SIZE'(DEPTH)) ||
                          ((apb.paddr & ADDR_SIZE'(LANES - 1)) != '0);
    assign wait_clamped = CNT_W'(clamp_wait(32'(wait_cfg), 32'(MAX_WAIT)));

`ifdef AMBA3_APB_PSTRB_EN
    assign wr_be = apb.pstrb;
`else
    logic unused_pstrb;
    assign unused_pstrb = ^apb.pstrb;
    assign wr_be        = '1;
`endif

    // Transfer state and response registers.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            pready_reg   <= 1'b0;
            pslverr_reg  <= 1'b0;
            rd_valid_reg <= 1'b0;
            addr_reg     <= '0;
            write_reg    <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            pready_reg   <= pready_next;
            pslverr_reg  <= pslverr_next;
            rd_valid_reg <= rd_valid_next;
            addr_reg     <= addr_next;
            write_reg    <= write_next;
            err_reg      <= err_next;
        end
    end

    // Next-state logic and RAM control. Reads are issued on the edge that
    // raises pready so the RAM output register is the read data; writes
    // happen on the completion edge, so reads and writes never collide.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        pready_next   = pready_reg;
        pslverr_next  = pslverr_reg;
        rd_valid_next = rd_valid_reg;
        addr_next     = addr_reg;
        write_next    = write_reg;
        err_next      = err_reg;
        ram_en        = 1'b0;
        ram_we        = 1'b0;
        ram_be        = '0;
        ram_addr      = addr_reg;

        case (state_reg)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    addr_next  = bus_idx;
                    write_next = apb.pwrite;
                    err_next   = addr_err;
                    if (wait_clamped == '0) begin
                        // Zero-wait: ready in the first access cycle.
                        state_next   = DONE;
                        cnt_next     = '0;
                        pready_next  = 1'b1;
                        pslverr_next = addr_err;
                        if (!apb.pwrite && !addr_err) begin
                            ram_en        = 1'b1;
                            ram_addr      = bus_idx;
                            rd_valid_next = 1'b1;
                        end
                    end else begin
                        state_next = WAIT;
                        cnt_next   = wait_clamped;
                    end
                end
            end
            WAIT: begin
                if (!apb.psel) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (apb.penable) begin
                    if (cnt_reg <= CNT_W'(1)) begin
                        state_next   = DONE;
                        cnt_next     = '0;
                        pready_next  = 1'b1;
                        pslverr_next = err_reg;
                        if (!write_reg && !err_reg) begin
                            ram_en        = 1'b1;
                            rd_valid_next = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
            end
            DONE: begin
                // Completion (psel & penable) or abort (psel low) both
                // return to IDLE; only a completed valid write hits memory.
                if (!apb.psel || apb.penable) begin
                    if (apb.psel && write_reg && !err_reg) begin
                        ram_en = 1'b1;
                        ram_we = 1'b1;
                        ram_be = wr_be;
                    end
                    state_next    = IDLE;
                    pready_next   = 1'b0;
                    pslverr_next  = 1'b0;
                    rd_valid_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Response bundle: read data only while a valid read is being answered.
    always_comb begin
        resp         = '0;
        resp.pslverr = pslverr_reg;
        if (rd_valid_reg) begin
            resp.prdata[DATA_SIZE-1:0] = ram_rdata;
        end
    end

    assign apb.prdata  = DATA_SIZE'(resp.prdata);
    assign apb.pslverr = resp.pslverr;
    assign apb.pready  = pready_reg;

    amba3_apb_mem_array #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk   (pclk),
        .en    (ram_en),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (apb.pwdata),
        .rdata (ram_rdata)
    );
endmodule

// File: tb/tb_amba3_apb_mem_slave.sv
// Self-checking bench for amba3_apb_mem_slave. A word-array memory model
// predicts each transfer's latency, read data and error; a negedge compare
// process checks pready every cycle and prdata/pslverr when ready.
// Honours AMBA3_APB_PSTRB_EN the same way the design does.
module tb_amba3_apb_mem_slave;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int MAXW  = 15;
    localparam int WW    = 4;

    logic          pclk = 1'b0;
    logic          preset;
    logic [WW-1:0] wait_cfg;

    always #5 pclk = ~pclk;

    amba3_apb_mem_slave_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

    amba3_apb_mem_slave #(
        .ADDR_SIZE (AW),
        .DATA_SIZE (DW),
        .DEPTH     (DEPTH),
        .MAX_WAIT  (MAXW)
    ) dut (
        .pclk     (pclk),
        .preset   (preset),
        .wait_cfg (wait_cfg),
        .apb      (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl     [DEPTH];
    bit          written [DEPTH];

    bit          chk_on = 1'b0;
    bit          in_access = 1'b0;
    int          acc_cycle = 0;
    int          exp_wait = 0;
    logic [31:0] exp_rdata = '0;
    bit          exp_err = 1'b0;

    logic [31:0] last_rdata;
    bit          last_err;
    int          last_lat;

    // Every cycle: pready must be high exactly in access cycle wait+1 of a
    // live transfer and low otherwise; when high, data and error must match.
    always @(negedge pclk) begin
        if (chk_on) begin
            bit want;
            want = in_access && (acc_cycle == exp_wait + 1);
            total++;
            if (bus.pready !== want) begin
                bad++;
                $display("FAIL pready t=%0t acc=%0d actual=%b required=%b",
                         $time, acc_cycle, bus.pready, want);
            end
            if (want && bus.pready === 1'b1) begin
                total++;
                if (bus.prdata !== exp_rdata) begin
                    bad++;
                    $display("FAIL prdata t=%0t actual=%h required=%h",
                             $time, bus.prdata, exp_rdata);
                end
                total++;
                if (bus.pslverr !== exp_err) begin
                    bad++;
                    $display("FAIL pslverr t=%0t actual=%b required=%b",
                             $time, bus.pslverr, exp_err);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic bit m_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  strb);
        logic [31:0] r;
        r = new_w;
`ifdef AMBA3_APB_PSTRB_EN
        for (int b = 0; b < 4; b++) begin
            if (!strb[b]) r[b*8 +: 8] = old_w[b*8 +: 8];
        end
`else
        if (strb == 4'hx) r = old_w;
`endif
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // One APB transfer starting now (called just after a rising edge).
    // abort_after > 0 drops psel after that many access cycles.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int wcfg, input int abort_after);
        int idx;
        bit err;
        err = m_err(addr);
        idx = int'(addr >> 2);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = data;
        bus.pstrb   = strb;
        wait_cfg    = WW'(wcfg);
        exp_wait    = (wcfg > MAXW) ? MAXW : wcfg;
        exp_err     = err;
        exp_rdata   = '0;
        if (!wr && !err) exp_rdata = mdl[idx];
        @(posedge pclk);
        #1;
        bus.penable = 1'b1;
        wait_cfg    = WW'($urandom_range(0, MAXW));
        acc_cycle   = 1;
        in_access   = 1'b1;
        forever begin
            @(negedge pclk);
            if (bus.pready === 1'b1) break;
            if (abort_after > 0 && acc_cycle >= abort_after) begin
                @(posedge pclk);
                #1;
                bus.psel = 1'b0; bus.penable = 1'b0; in_access = 1'b0;
                $display("xfer abort addr=%h after %0d access cycles", addr, acc_cycle);
                return;
            end
            if (acc_cycle > exp_wait + 3) begin
                total++;
                bad++;
                $display("FAIL timeout addr=%h actual=no pready required=pready in cycle %0d",
                         addr, exp_wait + 1);
                @(posedge pclk);
                #1;
                bus.psel = 1'b0; bus.penable = 1'b0; in_access = 1'b0;
                return;
            end
            @(posedge pclk);
            #1;
            acc_cycle++;
        end
        last_lat   = acc_cycle;
        last_rdata = bus.prdata;
        last_err   = bus.pslverr;
        @(posedge pclk);
        #1;
        if (wr && !err) begin
            mdl[idx]     = m_merge(mdl[idx], data, strb);
            written[idx] = 1'b1;
        end
        bus.psel = 1'b0; bus.penable = 1'b0; in_access = 1'b0;
        $display("xfer %s addr=%h wdata=%h wait=%0d lat=%0d rdata=%h err=%0d",
                 wr ? "wr" : "rd", addr, data, wcfg, last_lat, last_rdata, last_err);
    endtask

    initial begin
        int q[$];
        preset      = 1'b1;
        wait_cfg    = '0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = '0;
        bus.pwdata  = '0;
        bus.pstrb   = '0;
        repeat (3) @(posedge pclk);
        #1;
        preset = 1'b0;
        chk_on = 1'b1;
        @(negedge pclk);
        check("reset_pready", {31'd0, bus.pready}, 32'd0);
        check("reset_pslverr", {31'd0, bus.pslverr}, 32'd0);
        check("reset_prdata", bus.prdata, 32'd0);
        @(posedge pclk);
        #1;

        // Zero-wait write then read.
        xfer(1'b1, 32'h40, 32'h8000_3333, 4'hF, 0, 0);
        xfer(1'b0, 32'h40, 32'h0, 4'h0, 0, 0);
        check("zw_lat", 32'(last_lat), 32'd1);
        check("zw_rdata", last_rdata, 32'h8000_3333);
        check("zw_err", {31'd0, last_err}, 32'd0);

        // Five wait states.
        xfer(1'b1, 32'h84, 32'h0440_0011, 4'hF, 2, 0);
        idle(1);
        xfer(1'b0, 32'h84, 32'h0, 4'h0, 5, 0);
        check("w5_lat", 32'(last_lat), 32'd6);
        check("w5_rdata", last_rdata, 32'h0440_0011);

        // Errors: out of range, misaligned; memory unchanged after.
        xfer(1'b0, 32'h1000, 32'h0, 4'h0, 2, 0);
        check("err_oor_err", {31'd0, last_err}, 32'd1);
        check("err_oor_rdata", last_rdata, 32'd0);
        xfer(1'b0, 32'h42, 32'h0, 4'h0, 0, 0);
        check("err_mis_err", {31'd0, last_err}, 32'd1);
        check("err_mis_rdata", last_rdata, 32'd0);
        xfer(1'b1, 32'h1040, 32'hDEAD_BEEF, 4'hF, 1, 0);
        check("err_wr_err", {31'd0, last_err}, 32'd1);
        xfer(1'b1, 32'h41, 32'hDEAD_BEEF, 4'hF, 0, 0);
        xfer(1'b0, 32'h40, 32'h0, 4'h0, 3, 0);
        check("err_keep", last_rdata, 32'h8000_3333);

        // Byte strobes.
        xfer(1'b1, 32'h18, 32'h2244_6688, 4'hF, 1, 0);
        xfer(1'b1, 32'h18, 32'hFFFF_FFFF, 4'b0101, 0, 0);
        xfer(1'b0, 32'h18, 32'h0, 4'h0, 2, 0);
`ifdef AMBA3_APB_PSTRB_EN
        check("strb_rdata", last_rdata, 32'h22FF_66FF);
`else
        check("strb_rdata", last_rdata, 32'hFFFF_FFFF);
`endif

        // Abort by dropping psel.
        xfer(1'b1, 32'h40, 32'h1234_5678, 4'hF, 8, 3);
        idle(1);
        xfer(1'b0, 32'h40, 32'h0, 4'h0, 0, 0);
        check("abort_keep", last_rdata, 32'h8000_3333);

        // Reset in the middle of a waited write.
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 32'h40; bus.pwdata = 32'hA5A5_A5A5; bus.pstrb = 4'hF;
        wait_cfg = WW'(8);
        exp_wait = 8;
        @(posedge pclk);
        #1;
        bus.penable = 1'b1; acc_cycle = 1; in_access = 1'b1;
        repeat (2) begin
            @(posedge pclk);
            #1;
            acc_cycle++;
        end
        preset = 1'b1;
        @(posedge pclk);
        #1;
        preset = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0; in_access = 1'b0;
        @(negedge pclk);
        check("rst_mid_pready", {31'd0, bus.pready}, 32'd0);
        @(posedge pclk);
        #1;
        xfer(1'b0, 32'h40, 32'h0, 4'h0, 1, 0);
        check("rst_mid_keep", last_rdata, 32'h8000_3333);

        // Back-to-back random writes, then shuffled reads of every word.
        for (int i = 0; i < 1000; i++) begin
            xfer(1'b1, 32'(($urandom_range(0, 63) + 128) * 4), $urandom, 4'hF,
                 $urandom_range(0, MAXW), 0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        for (int i = 128; i < 192; i++) begin
            if (written[i]) q.push_back(i);
        end
        for (int i = q.size() - 1; i > 0; i--) begin
            int j;
            int t;
            j = $urandom_range(0, i);
            t = q[i]; q[i] = q[j]; q[j] = t;
        end
        foreach (q[k]) begin
            xfer(1'b0, 32'(q[k] * 4), 32'h0, 4'h0, $urandom_range(0, MAXW), 0);
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
